// File: rtl/dmem_store_buffer.sv
// Store buffer between the core data port and a slower data memory.
// Ports: core side (we_in/addr_in/wdata_in/rdata_out/stall), memory read
// (mem_rd_addr/mem_rd_data), memory write channel (mem_wr_valid/addr/
// data/ready), status (count/empty).
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_in,
  input  logic [31:0]   addr_in,
  input  logic [31:0]   wdata_in,
  output logic [31:0]   rdata_out,
  output logic          stall,
  output logic [31:0]   mem_rd_addr,
  input  logic [31:0]   mem_rd_data,
  output logic          mem_wr_valid,
  output logic [31:0]   mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  input  logic          mem_wr_ready,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_idx;
  logic [1:0]    w_unused_lsb;

  // Stores are full-word; the byte offset is dropped.
  assign w_unused_lsb = addr_in[1:0];

  assign w_full       = (r_count == CW'(DEPTH));
  assign stall        = we_in & w_full & ~reset;
  assign w_push       = we_in & ~w_full & ~reset;
  assign mem_wr_valid = (r_count != '0);
  assign w_pop        = mem_wr_valid & mem_wr_ready;

  assign empty        = ~mem_wr_valid;
  assign count        = r_count;

  assign mem_rd_addr  = {addr_in[31:2], 2'b00};
  assign mem_wr_addr  = {r_addr[r_head], 2'b00};
  assign mem_wr_data  = r_data[r_head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= addr_in[31:2];
      r_data[r_tail] <= wdata_in;
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    rdata_out = mem_rd_data;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == addr_in[31:2]))
        rdata_out = r_data[w_idx];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer.
// Memory writes are logged and compared against the program-order store list.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we_in = 1'b0;
  logic [31:0]   addr_in = '0;
  logic [31:0]   wdata_in = '0;
  logic [31:0]   rdata_out;
  logic          stall;
  logic [31:0]   mem_rd_addr;
  logic [31:0]   mem_rd_data = '0;
  logic          mem_wr_valid;
  logic [31:0]   mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_wr_ready = 1'b0;
  logic [CW-1:0] count;
  logic          empty;

  int n_chk = 0;
  int n_pass = 0;
  int n_keep;
  int cyc;
  int k;
  int cnt;
  int idx;

  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];

  dmem_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .we_in        (we_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .rdata_out    (rdata_out),
    .stall        (stall),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .count        (count),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && mem_wr_valid && mem_wr_ready) begin
      log_a.push_back(mem_wr_addr);
      log_d.push_back(mem_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    we_in = 1'b1;
    addr_in = a;
    wdata_in = d;
    #1;
    for (int n = 0; n < 50 && stall; n++) tick();
    chk("store_nostall", {31'b0, stall}, 32'd0);
    tick();
    exp_a.push_back({a[31:2], 2'b00});
    exp_d.push_back(d);
    we_in = 1'b0;
  endtask

  task automatic drain();
    mem_wr_ready = 1'b1;
    for (int n = 0; n < 50 && !empty; n++) tick();
    chk("drain_empty", {31'b0, empty}, 32'd1);
    mem_wr_ready = 1'b0;
  endtask

  initial begin
    // Reset, then idle
    mem_wr_ready = 1'b1;
    mem_rd_data = 32'h5A5A5A5A;
    repeat (2) tick();
    reset = 1'b0;
    addr_in = 32'h43;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_valid", {31'b0, mem_wr_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rdata", rdata_out, 32'h5A5A5A5A);
    chk("rst_rdaddr", mem_rd_addr, 32'h40);

    // Single store held until accepted
    mem_wr_ready = 1'b0;
    we_in = 1'b1;
    addr_in = 32'h44;
    wdata_in = 32'hDEADBEEF;
    #1;
    chk("st1_stall", {31'b0, stall}, 32'd0);
    chk("st1_nofwd", rdata_out, 32'h5A5A5A5A);
    tick();
    we_in = 1'b0;
    exp_a.push_back(32'h44);
    exp_d.push_back(32'hDEADBEEF);
    #1;
    chk("st1_valid", {31'b0, mem_wr_valid}, 32'd1);
    chk("st1_waddr", mem_wr_addr, 32'h44);
    chk("st1_wdata", mem_wr_data, 32'hDEADBEEF);
    chk("st1_count", 32'(count), 32'd1);
    chk("st1_fwd", rdata_out, 32'hDEADBEEF);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("hold_valid", {31'b0, mem_wr_valid}, 32'd1);
      chk("hold_waddr", mem_wr_addr, 32'h44);
      chk("hold_wdata", mem_wr_data, 32'hDEADBEEF);
    end
    chk("hold_nowr", 32'(log_a.size()), 32'd0);
    mem_wr_ready = 1'b1;
    tick();
    chk("st1_empty", {31'b0, empty}, 32'd1);
    chk("st1_nwr", 32'(log_a.size()), 32'd1);
    mem_wr_ready = 1'b0;

    // Youngest-match forwarding
    mem_rd_data = 32'hAAAAAAAA;
    store(32'h10, 32'h11111111);
    store(32'h10, 32'h22222222);
    addr_in = 32'h12;
    #1;
    chk("fwd_young", rdata_out, 32'h22222222);
    addr_in = 32'h14;
    #1;
    chk("fwd_miss", rdata_out, 32'hAAAAAAAA);
    chk("fwd_count", 32'(count), 32'd2);
    chk("fwd_head", mem_wr_data, 32'h11111111);
    drain();
    chk("fwd_nwr", 32'(log_a.size()), 32'd3);

    // Full buffer; stall ignores a same-cycle pop
    for (int j = 0; j < 4; j++)
      store(32'h100 + 32'(4 * j), 32'hF0000000 + 32'(j));
    chk("full_count", 32'(count), 32'd4);
    we_in = 1'b1;
    addr_in = 32'h200;
    wdata_in = 32'h55;
    mem_wr_ready = 1'b1;
    #1;
    chk("full_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("full_pop", 32'(count), 32'd3);
    chk("full_unstall", {31'b0, stall}, 32'd0);
    mem_wr_ready = 1'b0;
    tick();
    exp_a.push_back(32'h200);
    exp_d.push_back(32'h55);
    we_in = 1'b0;
    #1;
    chk("full_refill", 32'(count), 32'd4);
    chk("full_fwd_new", rdata_out, 32'h55);
    addr_in = 32'h104;
    #1;
    chk("full_fwd_old", rdata_out, 32'hF0000001);
    drain();
    chk("full_nwr", 32'(log_a.size()), 32'd8);

    // Wrap-around with toggling ready
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 200) begin
      we_in = 1'b1;
      addr_in = 32'h300 + 32'(4 * k);
      wdata_in = 32'hC0DE0000 + 32'(k);
      mem_wr_ready = cyc[0];
      #1;
      if (!stall) begin
        exp_a.push_back(addr_in);
        exp_d.push_back(wdata_in);
        k++;
      end
      tick();
      cyc++;
    end
    chk("wrap_pushed", 32'(k), 32'd10);
    we_in = 1'b0;
    mem_wr_ready = 1'b0;
    mem_rd_data = 32'hBBBBBBBB;
    #1;
    cnt = exp_a.size() - log_a.size();
    chk("wrap_count", 32'(count), 32'(cnt));
    for (int j = 0; j < cnt; j++) begin
      idx = exp_a.size() - 1 - j;
      addr_in = exp_a[idx];
      #1;
      chk("wrap_fwd", rdata_out, exp_d[idx]);
    end
    addr_in = 32'h300;
    #1;
    chk("wrap_drained", rdata_out, 32'hBBBBBBBB);
    drain();

    // Reset while stores are pending
    n_keep = exp_a.size();
    for (int j = 0; j < 3; j++)
      store(32'h400 + 32'(4 * j), 32'h77770000 + 32'(j));
    repeat (3) begin
      void'(exp_a.pop_back());
      void'(exp_d.pop_back());
    end
    #3;
    reset = 1'b1;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", {31'b0, mem_wr_valid}, 32'd0);
    chk("mrst_empty", {31'b0, empty}, 32'd1);
    we_in = 1'b1;
    addr_in = 32'h400;
    #1;
    chk("mrst_stall", {31'b0, stall}, 32'd0);
    tick();
    we_in = 1'b0;
    reset = 1'b0;
    mem_wr_ready = 1'b1;
    #1;
    chk("mrst_nofwd", rdata_out, 32'hBBBBBBBB);
    repeat (5) tick();
    chk("mrst_nwr", 32'(log_a.size()), 32'(n_keep));

    // Full write stream, in order
    chk("log_n", 32'(log_a.size()), 32'(exp_a.size()));
    for (int j = 0; j < exp_a.size() && j < log_a.size(); j++) begin
      chk("log_addr", log_a[j], exp_a[j]);
      chk("log_data", log_d[j], exp_d[j]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
